// File: rtl/rmii_tx.sv
// RMII Ethernet transmitter.
// Takes a payload dibit stream over a valid/ready handshake and sends it on
// RMII txd/txen, framed as preamble + SFD, payload, optional CRC-32 FCS and a
// fixed inter-packet gap.
module rmii_tx #(
   parameter int FCS_EN     = 1,
   parameter int IPG_CYCLES = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] axiid,
   input  logic       axiiv,
   output logic       axiir,
   output logic [1:0] txd,
   output logic       txen,
   output logic       busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_PAYLOAD  = 3'd2;
   localparam logic [2:0] S_FCS      = 3'd3;
   localparam logic [2:0] S_IPG      = 3'd4;

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

   // The IPG state lasts one cycle less than the gap because the first IDLE
   // cycle (txen still low) completes the gap when a new frame is waiting.
   localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);

   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_crc;
   logic [1:0]  r_txd;
   logic        r_txen;
   logic        r_busy;
   logic [31:0] w_crcNext;

   // Reflected CRC-32 advanced by one dibit, bit 0 entering first.
   function automatic logic [31:0] crcDibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 2; i++) begin
         if (x[0] ^ d[i]) begin
            x = {1'b0, x[31:1]} ^ CRC_POLY;
         end else begin
            x = {1'b0, x[31:1]};
         end
      end
      return x;
   endfunction

   // Next CRC value if the current input dibit is accepted.
   always_comb begin
      w_crcNext = crcDibit(r_crc, axiid);
   end

   // Framing state machine; the CRC register doubles as the FCS shift register
   // once the payload has ended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_crc   <= CRC_INIT;
         r_txd   <= 2'b00;
         r_txen  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (axiiv) begin
                  r_state <= S_PREAMBLE;
                  r_txen  <= 1'b1;
                  r_txd   <= 2'b01;
                  r_cnt   <= 16'd1;
                  r_crc   <= CRC_INIT;
                  r_busy  <= 1'b1;
               end
            end
            S_PREAMBLE: begin
               if (r_cnt == 16'd31) begin
                  r_txd   <= 2'b11;
                  r_state <= S_PAYLOAD;
                  r_cnt   <= 16'd0;
               end else begin
                  r_txd <= 2'b01;
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_PAYLOAD: begin
               if (axiiv) begin
                  r_txd <= axiid;
                  r_crc <= w_crcNext;
               end else if (FCS_EN != 0) begin
                  r_txd   <= ~r_crc[1:0];
                  r_crc   <= {2'b00, ~r_crc[31:2]};
                  r_state <= S_FCS;
                  r_cnt   <= 16'd1;
               end else begin
                  r_txd   <= 2'b00;
                  r_txen  <= 1'b0;
                  r_state <= S_IPG;
                  r_cnt   <= 16'd1;
               end
            end
            S_FCS: begin
               if (r_cnt == 16'd16) begin
                  r_txd   <= 2'b00;
                  r_txen  <= 1'b0;
                  r_state <= S_IPG;
                  r_cnt   <= 16'd1;
               end else begin
                  r_txd <= r_crc[1:0];
                  r_crc <= {2'b00, r_crc[31:2]};
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_IPG: begin
               if (r_cnt >= IPG_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_txd   <= 2'b00;
               r_txen  <= 1'b0;
               r_busy  <= 1'b0;
               r_cnt   <= 16'd0;
            end
         endcase
      end
   end

   assign axiir = (r_state == S_PAYLOAD);
   assign txd   = r_txd;
   assign txen  = r_txen;
   assign busy  = r_busy;

endmodule
